// File: rtl/reg_file_pkg.sv
// Shared constants, status type and pair-target helper for the parametrised register file.
package reg_file_pkg;

  localparam int DEF_W       = 16;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_SW      = 2;
  localparam int DEF_PAIR_HI = DEF_DEPTH - 1;
  localparam int DEF_PAIR_LO = DEF_DEPTH - 2;

  typedef logic [DEF_SW-1:0] status_t;

  typedef enum logic [1:0] {
    WR_NONE,
    WR_SINGLE,
    WR_PAIR
  } wr_kind_e;

  function automatic logic is_pair_target(input int unsigned a,
                                          input int unsigned hi,
                                          input int unsigned lo);
    return (a == hi) || (a == lo);
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback bus of the register file: write, pair, status, issue and read ports.
interface reg_file_mp_if #(
  parameter int W      = 16,
  parameter int DEPTH  = 8,
  parameter int NUM_RD = 2,
  parameter int SW     = 2
);
  localparam int AW = $clog2(DEPTH);

  logic                WriteEn;
  logic [AW-1:0]       Waddr;
  logic [W-1:0]        DataIn;
  logic                PairEn;
  logic [W-1:0]        HiIn;
  logic                StFlag;
  logic [SW-1:0]       StIn;
  logic                IssueEn;
  logic [AW-1:0]       IssueAddr;
  logic [NUM_RD*AW-1:0] Raddr;
  logic [NUM_RD*W-1:0] DataOut;
  logic [NUM_RD-1:0]   RdBusy;
  logic [DEPTH-1:0]    Busy;
  logic [SW-1:0]       S;

  modport master (
    output WriteEn, Waddr, DataIn, PairEn, HiIn, StFlag, StIn, IssueEn, IssueAddr, Raddr,
    input  DataOut, RdBusy, Busy, S
  );

  modport slave (
    input  WriteEn, Waddr, DataIn, PairEn, HiIn, StFlag, StIn, IssueEn, IssueAddr, Raddr,
    output DataOut, RdBusy, Busy, S
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: issue sets, completion clears, same-edge issue wins.
module reg_scoreboard #(
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 0
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [DEPTH-1:0]         clr,
  input  logic                     IssueEn,
  input  logic [$clog2(DEPTH)-1:0] IssueAddr,
  output logic [DEPTH-1:0]         Busy
);

  logic [DEPTH-1:0] set;

  always_comb begin
    set = '0;
    if (IssueEn) set[IssueAddr] = 1'b1;
    if (ZERO_REG != 0) set[0] = 1'b0;
  end

  // Set applied after clear so a new producer keeps the register busy.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) Busy <= '0;
    else       Busy <= (Busy & ~clr) | set;
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with pair writes, status register and scoreboard.
// Optional write-through forwarding: define REG_FILE_BYPASS_EN.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int NUM_RD   = 2,
  parameter int SW       = DEF_SW,
  parameter int PAIR_HI  = DEPTH - 1,
  parameter int PAIR_LO  = DEPTH - 2,
  parameter int ZERO_REG = 0
) (
  input  logic          Clk,
  input  logic          Reset,
  reg_file_mp_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     regs [DEPTH];
  logic [W-1:0]     wval [DEPTH];
  logic [DEPTH-1:0] wen;
  wr_kind_e         kind;

  always_comb begin
    kind = WR_NONE;
    if (bus.WriteEn) kind = bus.PairEn ? WR_PAIR : WR_SINGLE;
  end

  // Per-register write decode; shared by storage, scoreboard clear and forwarding.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wen[i]  = 1'b0;
      wval[i] = bus.DataIn;
      unique case (kind)
        WR_SINGLE: wen[i] = (bus.Waddr == AW'(i));
        WR_PAIR: begin
          wen[i] = is_pair_target(i, PAIR_HI, PAIR_LO);
          if (i == PAIR_HI) wval[i] = bus.HiIn;
        end
        default: ;
      endcase
      if (ZERO_REG != 0 && i == 0) wen[i] = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++)
        if (wen[i]) regs[i] <= wval[i];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)           bus.S <= '0;
    else if (bus.StFlag) bus.S <= bus.StIn;
  end

  reg_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .Clk       (Clk),
    .Reset     (Reset),
    .clr       (wen),
    .IssueEn   (bus.IssueEn),
    .IssueAddr (bus.IssueAddr),
    .Busy      (bus.Busy)
  );

  always_comb begin : rd_mux
    logic [AW-1:0] ra;
    logic [W-1:0]  rd;
    logic          rb;
    bus.DataOut = '0;
    bus.RdBusy  = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      ra = bus.Raddr[p*AW +: AW];
      rd = regs[ra];
      rb = bus.Busy[ra];
`ifdef REG_FILE_BYPASS_EN
      if (wen[ra]) begin
        rd = wval[ra];
        rb = 1'b0;
      end
`endif
      if (ZERO_REG != 0 && ra == '0) rd = '0;
      bus.DataOut[p*W +: W] = rd;
      bus.RdBusy[p]         = rb;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed and randomized check of reg_file_mp (ZERO_REG=1) against an array-based model.
module tb_reg_file_mp;
  import reg_file_pkg::*;

  logic Clk;
  logic Reset;
  int   total = 0;
  int   bad   = 0;
  logic run   = 1'b0;

  reg_file_mp_if #(.W(16), .DEPTH(8), .NUM_RD(2), .SW(2)) bus ();

  reg_file_mp #(
    .W(16), .DEPTH(8), .NUM_RD(2), .SW(2),
    .PAIR_HI(7), .PAIR_LO(6), .ZERO_REG(1)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [15:0] m_reg [8];
  logic [7:0]  m_busy;
  status_t     m_s;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_busy = '0;
    m_s    = '0;
  endtask

  task automatic model_wr(input logic [2:0] a, input logic [15:0] v);
    if (a != 3'd0) begin
      m_reg[a]  = v;
      m_busy[a] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (bus.WriteEn) begin
      if (bus.PairEn) begin
        model_wr(3'd7, bus.HiIn);
        model_wr(3'd6, bus.DataIn);
      end else begin
        model_wr(bus.Waddr, bus.DataIn);
      end
    end
    if (bus.StFlag) m_s = bus.StIn;
    if (bus.IssueEn && bus.IssueAddr != 3'd0) m_busy[bus.IssueAddr] = 1'b1;
  endtask

  function automatic logic written_now(input logic [2:0] a);
    if (!bus.WriteEn || a == 3'd0) return 1'b0;
    if (bus.PairEn) return (a == 3'd7) || (a == 3'd6);
    return a == bus.Waddr;
  endfunction

  function automatic logic [15:0] exp_data(input logic [2:0] a);
    if (a == 3'd0) return 16'h0;
`ifdef REG_FILE_BYPASS_EN
    if (written_now(a)) return (bus.PairEn && a == 3'd7) ? bus.HiIn : bus.DataIn;
`endif
    return m_reg[a];
  endfunction

  function automatic logic exp_rdbusy(input logic [2:0] a);
`ifdef REG_FILE_BYPASS_EN
    if (written_now(a)) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  always @(posedge Reset) model_reset();
  always @(posedge Clk) if (!Reset) model_edge();

  always @(negedge Clk) begin
    if (run && !Reset) begin
      chk("busy_vec", {24'h0, bus.Busy}, {24'h0, m_busy});
      chk("status", {30'h0, bus.S}, {30'h0, m_s});
      for (int p = 0; p < 2; p++) begin
        logic [2:0] a;
        a = bus.Raddr[p*3 +: 3];
        chk($sformatf("dout%0d_r%0d", p, a), {16'h0, bus.DataOut[p*16 +: 16]}, {16'h0, exp_data(a)});
        chk($sformatf("rdbusy%0d_r%0d", p, a), {31'h0, bus.RdBusy[p]}, {31'h0, exp_rdbusy(a)});
      end
    end
  end

  task automatic next();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    bus.WriteEn = 1'b0;
    bus.PairEn  = 1'b0;
    bus.StFlag  = 1'b0;
    bus.IssueEn = 1'b0;
  endtask

  initial begin
    model_reset();
    Reset = 1'b1;
    idle();
    bus.Waddr = '0; bus.DataIn = '0; bus.HiIn = '0; bus.StIn = '0;
    bus.IssueAddr = '0; bus.Raddr = '0;
    #3 Reset = 1'b0;
    run = 1'b1;

    // Reset while r3 is pending
    next(); idle();
    bus.WriteEn = 1'b1; bus.Waddr = 3'd2; bus.DataIn = 16'h5555;
    bus.StFlag = 1'b1; bus.StIn = 2'b01;
    bus.IssueEn = 1'b1; bus.IssueAddr = 3'd3;
    next(); idle();
    bus.Raddr = {3'd3, 3'd2};
    #2;
    chk("pre_rst_busy", {24'h0, bus.Busy}, 32'h08);
    chk("pre_rst_s", {30'h0, bus.S}, 32'h1);
    chk("pre_rst_r2", {16'h0, bus.DataOut[15:0]}, 32'h5555);
    Reset = 1'b1;
    #1;
    chk("rst_busy", {24'h0, bus.Busy}, 32'h0);
    chk("rst_dout", bus.DataOut, 32'h0);
    chk("rst_s", {30'h0, bus.S}, 32'h0);
    Reset = 1'b0;

    // Single write, same-cycle then next-cycle read
    next(); idle();
    bus.WriteEn = 1'b1; bus.Waddr = 3'd2; bus.DataIn = 16'hBEEF;
    bus.Raddr = {3'd1, 3'd2};
    #2;
`ifdef REG_FILE_BYPASS_EN
    chk("wr_same_cycle", {16'h0, bus.DataOut[15:0]}, 32'hBEEF);
`else
    chk("wr_same_cycle", {16'h0, bus.DataOut[15:0]}, 32'h0);
`endif
    next(); idle();
    #2;
    chk("wr_next_cycle", {16'h0, bus.DataOut[15:0]}, 32'hBEEF);

    // Pair write
    next(); idle();
    bus.WriteEn = 1'b1; bus.PairEn = 1'b1; bus.Waddr = 3'd1;
    bus.DataIn = 16'h1234; bus.HiIn = 16'h00AB;
    next(); idle();
    bus.Raddr = {3'd7, 3'd6};
    #2;
    chk("pair_hi_lo", bus.DataOut, 32'h00AB_1234);
    bus.Raddr = {3'd1, 3'd2};
    #1;
    chk("pair_r1_kept", {16'h0, bus.DataOut[31:16]}, 32'h0);
    chk("pair_r2_kept", {16'h0, bus.DataOut[15:0]}, 32'hBEEF);

    // Scoreboard issue then completion
    next(); idle();
    bus.IssueEn = 1'b1; bus.IssueAddr = 3'd5;
    bus.Raddr = {3'd0, 3'd5};
    for (int c = 0; c < 3; c++) begin
      next(); idle();
      #2;
      chk($sformatf("sb_rdbusy_c%0d", c), {31'h0, bus.RdBusy[0]}, 32'h1);
    end
    next(); idle();
    bus.WriteEn = 1'b1; bus.Waddr = 3'd5; bus.DataIn = 16'h0042;
    next(); idle();
    #2;
    chk("sb_busy5_clr", {31'h0, bus.Busy[5]}, 32'h0);
    chk("sb_r5_data", {16'h0, bus.DataOut[15:0]}, 32'h0042);

    // Issue and completion to the same register on one edge
    next(); idle();
    bus.IssueEn = 1'b1; bus.IssueAddr = 3'd4;
    bus.WriteEn = 1'b1; bus.Waddr = 3'd4; bus.DataIn = 16'h0007;
    bus.Raddr = {3'd0, 3'd4};
    next(); idle();
    #2;
    chk("coll_r4_data", {16'h0, bus.DataOut[15:0]}, 32'h0007);
    chk("coll_busy4", {31'h0, bus.Busy[4]}, 32'h1);

    // Zero register write plus status load
    next(); idle();
    bus.WriteEn = 1'b1; bus.Waddr = 3'd0; bus.DataIn = 16'hFFFF;
    bus.StFlag = 1'b1; bus.StIn = 2'b10;
    bus.Raddr = {3'd0, 3'd0};
    next(); idle();
    #2;
    chk("zero_r0", {16'h0, bus.DataOut[15:0]}, 32'h0);
    chk("status_10", {30'h0, bus.S}, 32'h2);

    // Randomized traffic with occasional mid-cycle resets
    for (int n = 0; n < 3000; n++) begin
      next();
      bus.WriteEn   = ($urandom_range(0, 1) == 0);
      bus.PairEn    = ($urandom_range(0, 3) == 0);
      bus.Waddr     = 3'($urandom_range(0, 7));
      bus.DataIn    = 16'($urandom);
      bus.HiIn      = 16'($urandom);
      bus.StFlag    = ($urandom_range(0, 9) < 3);
      bus.StIn      = 2'($urandom);
      bus.IssueEn   = ($urandom_range(0, 9) < 4);
      bus.IssueAddr = 3'($urandom_range(0, 7));
      bus.Raddr     = 6'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 Reset = 1'b1;
        #1 Reset = 1'b0;
      end
    end

    next(); idle();
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised successor to the processor's 8-entry, 16-bit register file.
- Generalised width, depth and read-port count; configurable fixed register pair for double-width ALU results (mul/div hi/lo); registered status field; pending-write scoreboard for multi-cycle units.
- Sits between decode (read addresses, issue) and writeback (data, pair and status writes).
- Feeds operand muxes and the hazard/stall logic.

Parameters:
- W, 16, data width in bits.
- DEPTH, 8, number of registers (power of two, >= 4).
- AW, $clog2(DEPTH), address width (derived).
- NUM_RD, 2, number of combinational read ports (1..4).
- SW, 2, status register width.
- PAIR_HI, DEPTH-1, register receiving the high half of a pair write.
- PAIR_LO, DEPTH-2, register receiving the low half of a pair write. Must differ from PAIR_HI.
- ZERO_REG, 0, 1 = register 0 reads as zero and ignores writes and issues.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- WriteEn  in  1  single write of DataIn to Waddr.
- Waddr  in  AW  write address.
- DataIn  in  W  write data; also the low half of a pair write.
- PairEn  in  1  with WriteEn: pair write.
- HiIn  in  W  high half of a pair write.
- StFlag  in  1  load status register.
- StIn  in  SW  status load value.
- IssueEn  in  1  mark IssueAddr pending (multi-cycle op dispatched).
- IssueAddr  in  AW  destination register of the dispatched op.
- Raddr  in  NUM_RD*AW  packed read addresses; port i = bits [i*AW +: AW].
- DataOut  out  NUM_RD*W  packed read data.
- RdBusy  out  NUM_RD  port i is reading a pending register.
- Busy  out  DEPTH  scoreboard vector.
- S  out  SW  status register.

Behaviour:
- Reset (async, any time, including while ops are pending):
  - all registers 0, S = 0, Busy = 0.
  - Outstanding pending marks are discarded. A completion arriving after reset is an ordinary write.
- Reads are combinational: DataOut[i] = Reg[Raddr[i]]. With ZERO_REG=1, address 0 reads 0.
- RdBusy[i] = Busy[Raddr[i]], combinational.
- Single write (WriteEn=1, PairEn=0):
  - Reg[Waddr] <= DataIn at the next edge.
  - Busy[Waddr] cleared.
- Pair write (WriteEn=1, PairEn=1):
  - Reg[PAIR_HI] <= HiIn and Reg[PAIR_LO] <= DataIn in the same edge. Waddr is ignored.
  - Busy[PAIR_HI] and Busy[PAIR_LO] are both cleared.
- PairEn with WriteEn=0 has no effect.
- Issue: Busy[IssueAddr] <= 1. Nothing else changes.
- Same-edge write/completion and issue to the same address: the issue wins, so Busy stays 1 (new producer). The register data is still updated.
- Issue to an already-busy register: it stays busy (no counting); the first completion clears it.
- ZERO_REG=1: writes, pair writes and issues targeting register 0 are dropped. Other targets of a pair write still update.
- StFlag: S <= StIn, independent of and concurrent with any write.
- Latency: write data is visible on DataOut the cycle after the edge; see the optional feature for same-cycle visibility.
- Scoreboard is advisory only. A write is never blocked; the stall decision belongs to the consumer.

Optional Feature:
- Macro REG_FILE_BYPASS_EN.
- Defined: write-through forwarding. If a read port addresses a register being written this cycle, DataOut returns the incoming value combinationally.
  - Single write: DataIn. Pair write: HiIn for PAIR_HI, DataIn for PAIR_LO.
  - RdBusy for that port is forced 0 the same cycle.
  - The zero-register rule still applies.
- Undefined: the read returns the old value and RdBusy reflects the pre-edge Busy. The new value is visible next cycle.

Decomposition:
- Package reg_file_pkg: default W/DEPTH constants, status typedef (logic [SW-1:0]), pair-address defaults, an is_pair_target() helper function.
- One natural sub-module: reg_scoreboard. It owns Busy, issue/clear/priority and reset, and is instantiated once.

Test Plan:
- Reset mid-issue: issue r3; assert Reset between edges; deassert. Expect Busy = 0, all DataOut = 0, S = 0 immediately, without a clock edge.
- Single write: write r2 = 16'hBEEF; next cycle Raddr port0 = 2 gives 16'hBEEF. Same-cycle read returns the old 0 without the macro, 16'hBEEF with it.
- Pair write: PairEn, DataIn = 16'h1234, HiIn = 16'h00AB, Waddr = 1. Expect r7 = 16'h00AB, r6 = 16'h1234; r1 unchanged.
- Scoreboard: issue r5; RdBusy = 1 on the port reading r5 for 3 cycles. Write r5 = 16'h0042: Busy[5] clears, and DataOut = 16'h0042 the next cycle.
- Collision: issue r4 and write r4 = 16'h0007 on the same edge. Expect r4 = 16'h0007 and Busy[4] still 1.
- ZERO_REG=1, StFlag: write r0 = 16'hFFFF → reads 0. Same edge StFlag with StIn = 2'b10 → S = 2'b10.
